// File: rtl/dac_serial_tx_pkg.sv
// Shared frame constants, FSM state encoding and frame builder for the DAC
// serial transmitter.
package dac_serial_tx_pkg;

  localparam int          FRAME_BITS = 16;
  localparam int          CODE_BITS  = 12;
  localparam logic [1:0]  PD_NORMAL  = 2'b00;
  localparam logic [11:0] MID_CODE   = 12'h800;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_e;

  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [CODE_BITS-1:0] code);
    return {2'b00, PD_NORMAL, code};
  endfunction

endpackage

// File: rtl/dac_serial_tx_if.sv
// Sample input and DAC serial output bundle for dac_serial_tx.
interface dac_serial_tx_if #(
  parameter int N = 25
);

  logic signed [N-1:0] Yk;
  logic                Bandera_Listo;
  logic                SYNC_n;
  logic                SCLK;
  logic                SDATA;
  logic                Busy;
  logic                Overrun;

  modport master (
    output Yk, Bandera_Listo,
    input  SYNC_n, SCLK, SDATA, Busy, Overrun
  );

  modport slave (
    input  Yk, Bandera_Listo,
    output SYNC_n, SCLK, SDATA, Busy, Overrun
  );

endinterface

// File: rtl/dac_code_conv.sv
// Converts a signed fixed-point sample into a saturated 12-bit offset-binary
// DAC code.
module dac_code_conv
  import dac_serial_tx_pkg::*;
#(
  parameter int N    = 25,
  parameter int FRAC = 20
) (
  input  logic signed [N-1:0]         yk,
  output logic        [CODE_BITS-1:0] code
);

  localparam int SH = FRAC - (CODE_BITS - 1);
  localparam logic signed [N-1:0] S_MAX = N'(2047);
  localparam logic signed [N-1:0] S_MIN = N'(-2048);

  logic signed [N-1:0] s;

  // Adding 2048 to an in-range 12-bit two's-complement value is an MSB flip.
  always_comb begin
    s = yk >>> SH;
    if (s > S_MAX) begin
      code = '1;
    end else if (s < S_MIN) begin
      code = '0;
    end else begin
      code = s[CODE_BITS-1:0] ^ MID_CODE;
    end
  end

endmodule

// File: rtl/dac_serial_tx.sv
// Captures filter samples into a one-deep pending slot and shifts them out as
// 16-bit SYNC_n/SCLK/SDATA frames to a DAC121S101-class converter.
module dac_serial_tx
  import dac_serial_tx_pkg::*;
#(
  parameter int N    = 25,
  parameter int FRAC = 20,
  parameter int DIV  = 4
) (
  input logic           Clk,
  input logic           Reset_n,
  dac_serial_tx_if.slave bus
);

  localparam int            CW        = $clog2(2 * DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(2 * DIV - 1);

  state_e                  state_q, state_d;
  logic                    flag_q, flag_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [CODE_BITS-1:0]    pend_code_q, pend_code_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [3:0]              bit_q, bit_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    phase_low_q, phase_low_d;
  logic                    sync_n_q, sync_n_d;
  logic                    sclk_q, sclk_d;
  logic                    sdata_q, sdata_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;
  logic [CODE_BITS-1:0]    code;
  logic                    new_sample;
  logic                    consume;

  dac_code_conv #(
    .N    (N),
    .FRAC (FRAC)
  ) u_conv (
    .yk   (bus.Yk),
    .code (code)
  );

  always_comb begin
    state_d      = state_q;
    flag_d       = bus.Bandera_Listo;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    cnt_d        = cnt_q;
    phase_low_d  = phase_low_q;
    sync_n_d     = sync_n_q;
    sclk_d       = sclk_q;
    sdata_d      = sdata_q;
    busy_d       = busy_q;
    overrun_d    = 1'b0;

    new_sample = bus.Bandera_Listo & ~flag_q;
    consume    = (state_q == LOAD);

    // A sample arriving while LOAD drains the slot refills it without overrun.
    if (new_sample) begin
      pend_valid_d = 1'b1;
      pend_code_d  = code;
      overrun_d    = pend_valid_q & ~consume;
    end else if (consume) begin
      pend_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (pend_valid_q) state_d = LOAD;
      end
      LOAD: begin
        shift_d     = make_frame(pend_code_q);
        bit_d       = 4'd15;
        cnt_d       = '0;
        phase_low_d = 1'b0;
        sync_n_d    = 1'b0;
        sclk_d      = 1'b1;
        sdata_d     = shift_d[FRAME_BITS-1];
        busy_d      = 1'b1;
        state_d     = SHIFT;
      end
      SHIFT: begin
        if (cnt_q != HALF_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (!phase_low_q) begin
            sclk_d      = 1'b0;
            phase_low_d = 1'b1;
          end else if (bit_q == 4'd0) begin
            sync_n_d = 1'b1;
            sclk_d   = 1'b1;
            sdata_d  = 1'b0;
            state_d  = GAP;
          end else begin
            bit_d       = bit_q - 4'd1;
            sclk_d      = 1'b1;
            sdata_d     = shift_q[bit_q-4'd1];
            phase_low_d = 1'b0;
          end
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      flag_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= '0;
      shift_q      <= '0;
      bit_q        <= '0;
      cnt_q        <= '0;
      phase_low_q  <= 1'b0;
      sync_n_q     <= 1'b1;
      sclk_q       <= 1'b1;
      sdata_q      <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flag_q       <= flag_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      cnt_q        <= cnt_d;
      phase_low_q  <= phase_low_d;
      sync_n_q     <= sync_n_d;
      sclk_q       <= sclk_d;
      sdata_q      <= sdata_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.SYNC_n  = sync_n_q;
  assign bus.SCLK    = sclk_q;
  assign bus.SDATA   = sdata_q;
  assign bus.Busy    = busy_q;
  assign bus.Overrun = overrun_q;

endmodule

// File: doc/dac_serial_tx.md
Name: dac_serial_tx

Overview:
- Output end of the filter chain: the low-pass filter receives ADC samples; this block sends filtered samples to the DAC.
- Captures the signed fixed-point filter output Yk on each completion flag and converts it to a 12-bit offset-binary DAC code with saturation.
- Shifts the code out as a 16-bit SPI-style frame (SYNC_n/SCLK/SDATA) to a DAC121S101-class converter.
- Holds one pending sample while a frame is in flight and flags overruns.

Parameters:
N, 25, width of the signed two's-complement input sample.
FRAC, 20, fractional bits of the input (1.0 = 2^FRAC).
DIV, 4, Clk cycles per SCLK half-period (DIV >= 2).

Ports:
Clk  input  1  system clock; the only clock.
Reset_n  input  1  asynchronous active-low reset.
Yk  input  N  signed filter output sample.
Bandera_Listo  input  1  sample-ready flag from the filter; a rising edge marks a new sample.
SYNC_n  output  1  DAC frame select, active low.
SCLK  output  1  DAC serial clock, idle high.
SDATA  output  1  serial data, MSB first.
Busy  output  1  high while a frame or the inter-frame gap is in progress.
Overrun  output  1  one-Clk pulse when a pending sample is overwritten.

Behaviour:
- Reset, asynchronous: SYNC_n=1, SCLK=1, SDATA=0, Busy=0, Overrun=0, state IDLE, edge detector cleared, pending buffer empty.
- Edge detect: Bandera_Listo is registered. A new sample is detected when the input is 1 and the registered copy is 0. A level held high is accepted only once.
- Capture: on a detected edge at Clk edge k, Yk is converted and written to the pending buffer (code plus valid bit) at edge k.
- Conversion (combinational):
  - s = Yk >>> (FRAC-11), arithmetic shift.
  - Clamp s to [-2048, 2047].
  - code = s + 2048, 12 bits.
  - 1.0 maps to 4095 via saturation; -1.0 maps to 0.
- Frame: {2'b00 don't-care, 2'b00 power-down = normal, code[11:0]}, MSB first.
- FSM:
  - IDLE: Busy=0. If the pending buffer is valid, go to LOAD.
  - LOAD: one cycle. Move pending to the shift register, clear the pending valid bit, drive SYNC_n=0 and SDATA=bit15, set Busy=1.
  - SHIFT: each bit is SCLK high for DIV cycles, then SCLK low for DIV cycles. The DAC samples on the falling SCLK edge. SDATA changes only on the cycle SCLK returns high. After the low phase of bit0, go to GAP.
  - GAP: SYNC_n=1, SCLK=1, SDATA=0 for 2*DIV cycles, then IDLE. A pending sample starts LOAD on the next cycle.
- Latency: edge detected at k → SYNC_n low at k+2. Frame from SYNC_n fall to SYNC_n rise is 32*DIV cycles. Minimum sample-to-sample period is 1+32*DIV+2*DIV+1 cycles (138 at DIV=4).
- Buffering: one pending slot.
  - A new edge while the slot is valid and not being consumed overwrites the slot and pulses Overrun for one cycle.
  - An edge in the same cycle as LOAD consumes the slot: the new sample goes into the emptied slot, with no overrun.
- Reset mid-frame: the frame is aborted immediately; outputs go to reset values and the pending sample is discarded.
- A Yk change during SHIFT has no effect: the shift register is isolated from the input.

Decomposition:
- Shared package:
  - Frame constants: FRAME_BITS=16, CODE_BITS=12, PD_NORMAL=2'b00, MID_CODE=12'h800.
  - FSM state encoding: IDLE, LOAD, SHIFT, GAP.
- One natural sub-module: dac_code_conv, the combinational shift/saturate/offset from N-bit Yk to a 12-bit code, parameterised on N and FRAC. It is verified standalone.
- The FSM, SCLK divider counter, bit counter and pending buffer stay in dac_serial_tx.

Test Plan:
- Reset mid-frame: pulse Reset_n low during bit 7 → SYNC_n=1, SCLK=1, Busy=0 immediately. The next sample starts a clean 16-bit frame.
- Single sample: Yk=0, rising Bandera_Listo → SYNC_n falls 2 cycles later. Frame 16'h0800 sampled on 16 SCLK falling edges. SYNC_n low for exactly 128 Clk (DIV=4). Busy drops after a 8-cycle gap.
- Conversion points:
  - Yk=0x080000 (0.5) → frame 16'h0C00.
  - Yk=-0x100000 (-1.0) → 16'h0000.
  - Yk=0x300000 (3.0) → 16'h0FFF.
  - Yk=-0x400000 → 16'h0000.
  - Yk=0x0FFE00 → 16'h0FFF.
- Held flag: Bandera_Listo high for 50 cycles → exactly one frame, no Overrun.
- Back-to-back: second edge during frame 1 (Yk=0x040000) → sent as frame 2 (16'h0A00) right after the gap, no Overrun.
- Overrun: three edges during one frame (values A, B, C) → Overrun pulses once, on the C edge. Next frame carries C; B is never transmitted.
